// File: rtl/sys1_pkg.sv
// Shared types and constants for the SEGA System 1 download sequencer.
package sys1_pkg;

  // Sequencer states: no image resident, download active, post-download hold, core running.
  typedef enum logic [1:0] {
    ST_NOROM  = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } load_state_t;

  // ioctl_index values understood by the sequencer.
  localparam logic [7:0] IDX_ROM  = 8'd0;
  localparam logic [7:0] IDX_MODE = 8'd1;
  localparam logic [7:0] IDX_DSW  = 8'd254;

  // SYSMODE register bit positions.
  localparam int unsigned SYSMODE_SYS2_BIT = 0;  // 0 = System 1, 1 = System 2
  localparam int unsigned SYSMODE_VERT_BIT = 1;  // 0 = horizontal, 1 = vertical
  localparam int unsigned SYSMODE_H240_BIT = 2;  // 0 = 256 wide, 1 = 240 wide

  // Datapath widths.
  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DSW_W  = 64;
  localparam int unsigned BCNT_W = 26;

endpackage

// File: rtl/sys1_reset_hold.sv
// Post-download reset hold counter: counts HOLD_CYCLES-1 down to zero.
module sys1_reset_hold #(
  parameter int unsigned HOLD_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(HOLD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next count: reload on load, otherwise decrement while enabled and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    done_d = (cnt_d == '0);
  end

  // Counter and registered terminal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/sys1_load_ctrl.sv
// Download sequencer: routes ioctl bytes to ROM/SYSMODE/DIP and owns the core reset.
module sys1_load_ctrl
  import sys1_pkg::*;
#(
  parameter logic [24:0] ROM_LIMIT   = 25'h20000,
  parameter int unsigned HOLD_CYCLES = 256
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_index,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  input  logic              user_rst,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_data,
  output logic [7:0]        sysmode,
  output logic [DSW_W-1:0]  dsw,
  output logic              core_reset,
  output logic              rom_loaded,
  output logic              overflow
);

  load_state_t       state_q, state_d;
  logic              dl_q, dl_d;
  logic              dl_rom_q, dl_rom_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              rom_we_q, rom_we_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rom_data_q, rom_data_d;
  logic [7:0]        sysmode_q, sysmode_d;
  logic [DSW_W-1:0]  dsw_q, dsw_d;
  logic              core_reset_q, core_reset_d;
  logic              rom_loaded_q, rom_loaded_d;
  logic              overflow_q, overflow_d;

  logic dl_rise_c, dl_fall_c, accept_c;
  logic hold_load_c, hold_en_c, hold_done;

  // Settle interval timer.
  sys1_reset_hold #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clk  (clk_sys),
    .rst_n(reset_n),
    .load (hold_load_c),
    .en   (hold_en_c),
    .done (hold_done)
  );

  // Byte routing, download bookkeeping and sequencer next state.
  always_comb begin
    state_d      = state_q;
    dl_d         = ioctl_download;
    dl_rom_d     = dl_rom_q;
    byte_cnt_d   = byte_cnt_q;
    rom_we_d     = 1'b0;
    rom_addr_d   = rom_addr_q;
    rom_data_d   = rom_data_q;
    sysmode_d    = sysmode_q;
    dsw_d        = dsw_q;
    rom_loaded_d = rom_loaded_q;
    overflow_d   = overflow_q;
    hold_load_c  = 1'b0;

    dl_rise_c = ioctl_download & ~dl_q;
    dl_fall_c = ~ioctl_download & dl_q;
    accept_c  = ioctl_wr & ioctl_download;

    // A new ROM download invalidates the resident image before any byte lands.
    if (dl_rise_c) begin
      dl_rom_d = (ioctl_index == IDX_ROM);
      if (ioctl_index == IDX_ROM) begin
        byte_cnt_d   = '0;
        overflow_d   = 1'b0;
        rom_loaded_d = 1'b0;
      end
    end

    if (accept_c) begin
      if (ioctl_index == IDX_ROM) begin
        if (ioctl_addr < ROM_LIMIT) begin
          rom_we_d   = 1'b1;
          rom_addr_d = ioctl_addr;
          rom_data_d = ioctl_dout;
          if (byte_cnt_d != '1) begin
            byte_cnt_d = byte_cnt_d + BCNT_W'(1);
          end
        end else begin
          overflow_d = 1'b1;
        end
      end else if ((ioctl_index == IDX_MODE) && (ioctl_addr == '0)) begin
        sysmode_d = ioctl_dout;
      end else if ((ioctl_index == IDX_DSW) && (ioctl_addr[24:3] == '0)) begin
        dsw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
      end
    end

    unique case (state_q)
      ST_LOAD: begin
        if (dl_fall_c) begin
          if (dl_rom_q && (byte_cnt_q != '0)) begin
            rom_loaded_d = 1'b1;
          end
          if (rom_loaded_d) begin
            state_d     = ST_SETTLE;
            hold_load_c = 1'b1;
          end else begin
            state_d = ST_NOROM;
          end
        end
      end
      ST_SETTLE: begin
        if (hold_done) begin
          state_d = ST_RUN;
        end
      end
      ST_NOROM, ST_RUN: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_NOROM;
      end
    endcase

    // Any download start wins, including one that aborts the settle interval.
    if (dl_rise_c) begin
      state_d     = ST_LOAD;
      hold_load_c = 1'b0;
    end

    hold_en_c    = (state_q == ST_SETTLE);
    core_reset_d = (state_d == ST_RUN) ? user_rst : 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_NOROM;
      // Held high so a download already in flight at reset release is not seen as a new start.
      dl_q         <= 1'b1;
      dl_rom_q     <= 1'b0;
      byte_cnt_q   <= '0;
      rom_we_q     <= 1'b0;
      rom_addr_q   <= '0;
      rom_data_q   <= '0;
      sysmode_q    <= '0;
      dsw_q        <= '1;
      core_reset_q <= 1'b1;
      rom_loaded_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_d;
      dl_rom_q     <= dl_rom_d;
      byte_cnt_q   <= byte_cnt_d;
      rom_we_q     <= rom_we_d;
      rom_addr_q   <= rom_addr_d;
      rom_data_q   <= rom_data_d;
      sysmode_q    <= sysmode_d;
      dsw_q        <= dsw_d;
      core_reset_q <= core_reset_d;
      rom_loaded_q <= rom_loaded_d;
      overflow_q   <= overflow_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign sysmode    = sysmode_q;
  assign dsw        = dsw_q;
  assign core_reset = core_reset_q;
  assign rom_loaded = rom_loaded_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sys1_load_ctrl.sv
// Scoreboard bench for sys1_load_ctrl: random downloads against a byte-level model.
module tb_sys1_load_ctrl;
  import sys1_pkg::*;

  localparam int unsigned LIMIT = 32'h20000;
  localparam int unsigned HOLD  = 256;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_rst;
  logic        rom_we;
  logic [24:0] rom_addr;
  logic [7:0]  rom_data;
  logic [7:0]  sysmode;
  logic [63:0] dsw;
  logic        core_reset;
  logic        rom_loaded;
  logic        overflow;

  sys1_load_ctrl #(
    .ROM_LIMIT  (25'h20000),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .user_rst      (user_rst),
    .rom_we        (rom_we),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .sysmode       (sysmode),
    .dsw           (dsw),
    .core_reset    (core_reset),
    .rom_loaded    (rom_loaded),
    .overflow      (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } rom_wr_t;

  rom_wr_t     exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Reference model of the externally visible state.
  logic [7:0] m_sysmode;
  logic [7:0] m_dsw[8];
  bit         m_loaded;
  bit         m_ovf;
  bit         m_rom_dl;
  int         m_cnt;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ROM write monitor: every rom_we pulse must match the oldest expected write.
  always @(negedge clk_sys) begin
    if (reset_n && rom_we) begin
      if (exp_q.size() == 0) begin
        check("rom_we_unexpected", 64'(rom_addr), 64'h1_0000_0000);
      end else begin
        rom_wr_t e;
        e = exp_q.pop_front();
        check("rom_addr", 64'(rom_addr), 64'(e.addr));
        check("rom_data", 64'(rom_data), 64'(e.data));
        check("rom_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  function automatic logic [63:0] m_dsw_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = m_dsw[i];
    return f;
  endfunction

  task automatic model_reset();
    m_sysmode = 8'h00;
    for (int i = 0; i < 8; i++) m_dsw[i] = 8'hFF;
    m_loaded = 1'b0;
    m_ovf    = 1'b0;
    m_rom_dl = 1'b0;
    m_cnt    = 0;
    exp_q.delete();
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
    check({tag, "_rom_we"}, 64'(rom_we), 64'd0);
    check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
    check({tag, "_rom_data"}, 64'(rom_data), 64'd0);
    check({tag, "_sysmode"}, 64'(sysmode), 64'd0);
    check({tag, "_dsw"}, dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    check({tag, "_rom_loaded"}, 64'(rom_loaded), 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    m_rom_dl       = (idx == IDX_ROM);
    if (m_rom_dl) begin
      m_cnt    = 0;
      m_ovf    = 1'b0;
      m_loaded = 1'b0;
    end
    tick();
    check("core_reset_on_start", 64'(core_reset), 64'd1);
    check("rom_loaded_on_start", 64'(rom_loaded), 64'(m_loaded));
    check("overflow_on_start", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input int gap);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    if (ioctl_index == IDX_ROM) begin
      if (int'(addr) < int'(LIMIT)) begin
        exp_q.push_back('{addr: addr, data: data, cyc: cyc + 1});
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (ioctl_index == IDX_MODE && addr == 25'd0) begin
      m_sysmode = data;
    end else if (ioctl_index == IDX_DSW && addr < 25'd8) begin
      m_dsw[addr[2:0]] = data;
    end
    tick();
    ioctl_wr = 1'b0;
    repeat (gap) tick();
  endtask

  // Ends the download and checks the hold length, or that the core stays held.
  task automatic end_dl(input string tag);
    int n;
    ioctl_download = 1'b0;
    if (m_rom_dl && m_cnt > 0) m_loaded = 1'b1;
    tick();
    n = 1;
    check({tag, "_rom_loaded"}, 64'(rom_loaded), 64'(m_loaded));
    check({tag, "_overflow"}, 64'(overflow), 64'(m_ovf));
    check({tag, "_sysmode"}, 64'(sysmode), 64'(m_sysmode));
    check({tag, "_dsw"}, dsw, m_dsw_flat());
    while (core_reset && n < int'(HOLD) + 20) begin
      tick();
      n++;
    end
    if (m_loaded) check({tag, "_settle_len"}, 64'(n), 64'(HOLD + 1));
    else          check({tag, "_held_in_norom"}, 64'(core_reset), 64'd1);
    check({tag, "_rom_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [24:0] rand_addr(input logic [7:0] idx);
    if (idx == IDX_ROM) begin
      if ($urandom_range(0, 3) == 0) return 25'(LIMIT + $urandom_range(0, 1000));
      return 25'($urandom_range(0, LIMIT - 1));
    end
    if (idx == IDX_MODE) return 25'($urandom_range(0, 2));
    if (idx == IDX_DSW)  return 25'($urandom_range(0, 15));
    return 25'($urandom_range(0, 255));
  endfunction

  initial begin
    bit          gap_seen;
    logic [7:0]  idx;
    int          nb;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    user_rst       = 1'b0;
    model_reset();
    #12;
    check_reset_vals("por");
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // Directed 4-byte ROM download.
    start_dl(IDX_ROM);
    send_byte(25'd0, 8'hA5, 1);
    send_byte(25'd1, 8'h5A, 1);
    send_byte(25'd2, 8'h00, 1);
    send_byte(25'd3, 8'hFF, 1);
    end_dl("rom4");
    check("rom4_running", 64'(core_reset), 64'd0);

    // Strobe without download is ignored.
    ioctl_index = IDX_MODE;
    ioctl_addr  = 25'd0;
    ioctl_dout  = ~m_sysmode;
    ioctl_wr    = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    tick();
    check("idle_strobe_sysmode", 64'(sysmode), 64'(m_sysmode));
    check("idle_strobe_core_reset", 64'(core_reset), 64'd0);

    // user_rst in RUN, one cycle latency.
    user_rst = 1'b1;
    check("user_rst_latency", 64'(core_reset), 64'd0);
    tick();
    check("user_rst_assert", 64'(core_reset), 64'd1);
    user_rst = 1'b0;
    tick();
    check("user_rst_release", 64'(core_reset), 64'd0);

    // DIP bytes: in-range address 2, out-of-range address 8.
    start_dl(IDX_DSW);
    send_byte(25'd2, 8'h3C, 0);
    send_byte(25'd8, 8'h11, 1);
    check("dsw_byte2", 64'(dsw[23:16]), 64'h3C);
    check("dsw_byte0", 64'(dsw[7:0]), 64'hFF);
    end_dl("dsw");

    // Out-of-range ROM byte only: dropped, sticky overflow, no image.
    start_dl(IDX_ROM);
    send_byte(25'h20000, 8'h77, 1);
    end_dl("ovf");
    check("ovf_flag", 64'(overflow), 64'd1);

    // Next ROM download clears overflow and loads at the last valid address.
    start_dl(IDX_ROM);
    send_byte(25'h1FFFF, 8'hAB, 0);
    send_byte(25'h00000, 8'h11, 1);
    end_dl("edge_rom");

    // Abort the settle interval with ten cycles left.
    start_dl(IDX_ROM);
    for (int i = 0; i < 3; i++) send_byte(25'(i), 8'($urandom), 0);
    tick();
    ioctl_download = 1'b0;
    m_loaded = 1'b1;
    gap_seen = 1'b0;
    repeat (HOLD - 10) begin
      tick();
      if (!core_reset) gap_seen = 1'b1;
    end
    check("abort_rom_q_empty", 64'(exp_q.size()), 64'd0);
    start_dl(IDX_DSW);
    check("abort_no_gap", 64'(gap_seen), 64'd0);
    send_byte(25'd5, 8'h96, 1);
    end_dl("abort");

    // Randomized downloads.
    for (int d = 0; d < 12; d++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: idx = IDX_ROM;
        6, 7:             idx = IDX_DSW;
        8:                idx = IDX_MODE;
        default:          idx = 8'd7;
      endcase
      nb = int'($urandom_range(0, 10));
      start_dl(idx);
      for (int b = 0; b < nb; b++) send_byte(rand_addr(idx), 8'($urandom), int'($urandom_range(0, 2)));
      tick();
      end_dl("rand");
    end

    // Reset in the middle of a SYSMODE download while an image is resident.
    start_dl(IDX_ROM);
    send_byte(25'd9, 8'h42, 1);
    end_dl("pre_rst");
    start_dl(IDX_MODE);
    send_byte(25'd0, 8'h05, 1);
    check("pre_rst_loaded", 64'(rom_loaded), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_load");
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();
    end_dl("post_rst");

    check("final_rom_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sys1_load_ctrl.md
# sys1_load_ctrl

Download sequencer for the SEGA System 1 core. It sits between the HPS `ioctl` stream and `SEGASYSTEM1`. It routes download bytes to the ROM write port, the SYSMODE register and the DIP-switch bank. It also owns the core's reset, holding the core in reset until a ROM image is resident, during every download, and for a settle interval afterwards.

## Interface
- `ROM_LIMIT`, default 25'h20000: first ROM byte address that is out of range. Writes at or above it are dropped.
- `HOLD_CYCLES`, default 256: number of `clk_sys` cycles the core stays in reset after a download ends (minimum 1).
- `clk_sys` in 1: system clock, 48 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_download` in 1: download in progress.
- `ioctl_wr` in 1: byte strobe, one cycle.
- `ioctl_index` in 8: 0 = ROM, 1 = SYSMODE, 254 = DIP switches.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `user_rst` in 1: active-high menu/button reset request.
- `rom_we` in 1: ROM write enable, one cycle.
- `rom_addr` out 25: ROM write address.
- `rom_data` out 8: ROM write data.
- `sysmode` out 8: [0] SYS1/SYS2, [1] H/V, [2] H256/H240.
- `dsw` out 64: DIP bytes 0..7, byte n at [8n+7:8n].
- `core_reset` out 1: active-high reset to the game core.
- `rom_loaded` out 1: a valid ROM image is resident.
- `overflow` out 1: sticky flag, at least one ROM byte was dropped.

## Operation
- Byte acceptance requires `ioctl_wr & ioctl_download`. A strobe with `ioctl_download` low is ignored.
- Routing:
  - Index 0: if addr < `ROM_LIMIT`, forward to the ROM port and increment `byte_cnt`. Otherwise drop the byte and set `overflow`.
  - Index 1 with addr == 0: load `sysmode`.
  - Index 254 with addr[24:3] == 0: load `dsw` byte addr[2:0].
  - Any other index or address: ignored.
- FSM states:
  - **NOROM** (reset state): `core_reset` = 1.
  - **LOAD**: entered from any state on the rising edge of `ioctl_download`. `core_reset` = 1.
  - **SETTLE**: `core_reset` = 1. A counter loads `HOLD_CYCLES-1` and decrements.
  - **RUN**: `core_reset` = `user_rst`.
- Transitions:
  - LOAD → SETTLE on the falling edge of `ioctl_download`, if `rom_loaded` is 1 after the update described below. Otherwise LOAD → NOROM.
  - SETTLE → RUN when the counter reaches 0.
- Start of a download: on entering LOAD with `ioctl_index` == 0, clear `byte_cnt`, clear `overflow` and clear `rom_loaded`.
- End of a download: an index-0 download that ends with `byte_cnt` != 0 sets `rom_loaded`. A zero-byte ROM download leaves `rom_loaded` at 0.
- Downloads with index 1 or 254 do not change `rom_loaded`. They still pass through LOAD and SETTLE, so the core restarts with the new DIP and SYSMODE values.
- A download that starts during SETTLE aborts the counter and goes to LOAD.
- `user_rst` during LOAD or SETTLE has no effect on sequencing.

## Timing
- ROM port latency: `rom_we`, `rom_addr` and `rom_data` are registered and valid exactly 1 cycle after the accepted strobe.
- `sysmode` and `dsw` update on the accepting edge and are visible the next cycle.
- `core_reset`:
  - Rises on the cycle after the `ioctl_download` rising edge is sampled.
  - Falls exactly `HOLD_CYCLES` cycles after the cycle in which the download falling edge is sampled (SETTLE lasts `HOLD_CYCLES` cycles).
  - Is registered and glitch-free.
- Edge detection uses a 1-cycle registered copy of `ioctl_download`.
- Reset values:
  - state = NOROM, `core_reset` = 1.
  - `rom_we` = 0, `rom_addr` = 0, `rom_data` = 0.
  - `sysmode` = 0, `dsw` = all 8'hFF.
  - `rom_loaded` = 0, `overflow` = 0, counters = 0.
- Reset mid-download: all state returns to reset values immediately and asynchronously. The remainder of the interrupted download is treated as a fresh LOAD only if a new rising edge of `ioctl_download` occurs.

## Structure
- Shared package `sys1_pkg`:
  - State enum `load_state_t`.
  - Index constants `IDX_ROM` = 0, `IDX_MODE` = 1, `IDX_DSW` = 254.
  - SYSMODE bit positions.
- One sub-module, `sys1_reset_hold`: the SETTLE down-counter, with inputs load and enable and output done.
- Routing and the FSM live in the top level of the block.

## Test plan
- Index-0 download of 4 bytes at addresses 0..3 with data A5, 5A, 00, FF → 4 `rom_we` pulses, each 1 cycle after its strobe with matching address and data. Then `rom_loaded` = 1 and `core_reset` falls 256 cycles after the download falls.
- Index-0 byte at addr 25'h20000 → no `rom_we` and `overflow` = 1. The next index-0 download clears `overflow` on start.
- Index-254 writes at addr 2 = 8'h3C and addr 8 = 8'h11 → `dsw[23:16]` = 3C and byte 0 stays FF. The core re-enters reset, then returns to RUN.
- `ioctl_wr` pulse with `ioctl_download` = 0 and index 1 → `sysmode` unchanged and no FSM change.
- New download starts with the SETTLE counter at 10 → state goes to LOAD and `core_reset` stays 1 with no gap.
- `reset_n` asserted mid-LOAD → outputs immediately at reset values, `rom_loaded` = 0, state NOROM. `user_rst` in RUN → `core_reset` follows it with 1-cycle latency.
